// File: rtl/nms_window_feeder.sv
// Raster-scans the FAST score RAM and presents a 3x3 window per interior pixel to NMS.
// Optional build macro NMS_FEED_SKIP_ZERO_EN suppresses windows whose centre score is zero.
module nms_window_feeder #(
    parameter int IMG_W = 181,
    parameter int IMG_H = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        rd_en,
    output logic [14:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        out_valid,
    output logic [7:0]  ref_score,
    output logic [63:0] adj_score,
    output logic [14:0] ref_addr,
    output logic [1:0]  dbgState
);

    localparam int N = IMG_W * IMG_H;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [14:0] LAST_ADDR = 15'(N - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feedState_t;

    // Handshake: start is honoured only in IDLE; busy covers the cycle after
    // acceptance through the one-cycle done pulse; out_valid has no back-pressure.
    feedState_t state, stateNext;

    logic [14:0]   addrCnt;
    logic          drainCnt;
    logic          rdValid;
    logic [14:0]   rdAddrQ;
    logic [CW-1:0] colCnt;
    logic [RW-1:0] rowCnt;
    logic [7:0]    lb1 [IMG_W];
    logic [7:0]    lb2 [IMG_W];
    logic [7:0]    win [3][3];
    logic [7:0]    winNext [3][3];
    logic [7:0]    aboveOne;
    logic [7:0]    aboveTwo;
    logic          interior;
    logic          emit;

    assign dbgState = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = READ;
            READ:    if (addrCnt == LAST_ADDR) stateNext = DRAIN;
            DRAIN:   if (drainCnt) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addrCnt  <= '0;
            drainCnt <= 1'b0;
        end else begin
            drainCnt <= (state == DRAIN) ? ~drainCnt : 1'b0;
            if (state == READ) begin
                addrCnt <= addrCnt + 15'd1;
            end else begin
                addrCnt <= '0;
            end
        end
    end

    // Read port and control outputs; rdValid marks the cycle rd_data returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdValid <= 1'b0;
            rdAddrQ <= '0;
        end else begin
            rd_en   <= (state == READ);
            if (state == READ) begin
                rd_addr <= addrCnt;
            end
            busy    <= (state != IDLE);
            done    <= (state == DONE);
            rdValid <= rd_en;
            rdAddrQ <= rd_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            colCnt <= '0;
            rowCnt <= '0;
        end else if (rdValid) begin
            if (colCnt == LAST_COL) begin
                colCnt <= '0;
                rowCnt <= rowCnt + RW'(1);
            end else begin
                colCnt <= colCnt + CW'(1);
            end
        end
    end

    always_comb begin
        aboveTwo = lb2[colCnt];
        aboveOne = lb1[colCnt];
        for (int r = 0; r < 3; r++) begin
            winNext[r][0] = win[r][1];
            winNext[r][1] = win[r][2];
        end
        winNext[0][2] = aboveTwo;
        winNext[1][2] = aboveOne;
        winNext[2][2] = rd_data;
        // Columns 0/1 would mix in pixels from the previous row, so they never emit.
        interior = (int'(colCnt) >= 2) && (int'(rowCnt) >= 2);
`ifdef NMS_FEED_SKIP_ZERO_EN
        emit = rdValid && interior && (winNext[1][1] != 8'd0);
`else
        emit = rdValid && interior;
`endif
    end

    always_ff @(posedge clk) begin
        if (rdValid) begin
            lb2[colCnt] <= aboveOne;
            lb1[colCnt] <= rd_data;
            win         <= winNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            ref_score <= '0;
            adj_score <= '0;
            ref_addr  <= '0;
        end else begin
            out_valid <= emit;
            if (rdValid) begin
                ref_score <= winNext[1][1];
                adj_score <= {winNext[0][0], winNext[0][1], winNext[0][2],
                              winNext[1][0], winNext[1][2],
                              winNext[2][0], winNext[2][1], winNext[2][2]};
                ref_addr  <= rdAddrQ;
            end
        end
    end

endmodule

// File: doc/nms_window_feeder.md
# nms_window_feeder

Streams the FAST corner-score image out of the score RAM in raster order. Two line buffers build a 3x3 neighbourhood for every interior pixel. Each window is presented to the non-maximum-suppression datapath as a centre score, eight packed neighbour scores and the raster address of the window's bottom-right pixel. It sits between the score RAM (written by the FAST score stage) and the NMS datapath, and drives the scan with a start/busy/done handshake.

## Interface
- `IMG_W`, 181, image width in pixels (row stride of score RAM)
- `IMG_H`, 120, image height in rows; `IMG_W*IMG_H` must be ≤ 32768
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse, begins a frame scan; ignored unless IDLE
- `busy`  out  1  high from the cycle after `start` is accepted through the `done` cycle
- `done`  out  1  one-cycle pulse, scan complete
- `rd_en`  out  1  score RAM read enable
- `rd_addr`  out  15  score RAM read address
- `rd_data`  in  8  score RAM data; valid exactly one cycle after `rd_en`
- `out_valid`  out  1  window outputs valid this cycle
- `ref_score`  out  8  centre score
- `adj_score`  out  64  neighbours, packed as listed under Operation
- `ref_addr`  out  15  raster address of the bottom-right window pixel; centre address = `ref_addr - IMG_W - 1` (182 at defaults)

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE -> READ on `start`.
  - READ -> DRAIN after issuing address `N-1`, where `N = IMG_W*IMG_H`.
  - DRAIN lasts 2 cycles, then -> DONE.
  - DONE lasts 1 cycle, then -> IDLE.
- READ: `rd_en`=1 and `rd_addr` increments by 1 per cycle from 0 to `N-1`. No gaps, no stalls.
- Column/row counters track each returning `rd_data` sample, with column wrap at `IMG_W-1`.
- Line buffers `lb1`/`lb2` each hold `IMG_W` x 8 bits.
  - On sample `p(r,c)`: read `lb1[c]` as `p(r-1,c)` and `lb2[c]` as `p(r-2,c)`.
  - Then write `lb2[c]` <= `lb1[c]` and `lb1[c]` <= `p(r,c)`.
- A 3x3 window register shifts left by one column per sample. The new right column is (`p(r-2,c)`, `p(r-1,c)`, `p(r,c)`).
- `adj_score` packing (top-left origin):
  - [63:56] TL, [55:48] T, [47:40] TR
  - [39:32] L, [31:24] R
  - [23:16] BL, [15:8] B, [7:0] BR
- `ref_score` is the window centre.
- `out_valid` is asserted only when the sample's `c ≥ 2` and `r ≥ 2`. This gives `(IMG_W-2)*(IMG_H-2)` windows per frame. No window straddles a row wrap: column-0/1 windows are suppressed.
- Window contents left over from the previous row or frame never reach a valid output.
- `start` while busy is ignored. A new `start` in the DONE cycle is ignored; it is accepted from IDLE only.
- `rst` at any time: FSM returns to IDLE and counters clear. In-flight reads are discarded. Line-buffer contents need not be cleared.

## Timing
- Reset values:
  - `busy`, `done`, `rd_en`, `out_valid` = 0
  - `rd_addr`, `ref_addr` = 0
  - `ref_score` = 0, `adj_score` = 0
- `start` sampled at edge k: `rd_addr`=a is driven in cycle k+1+a.
- Window whose bottom-right is address a: outputs valid in cycle k+3+a, i.e. 2 cycles after the address.
- Last window at cycle k+N+2; `done` at cycle k+N+3; `busy` falls at cycle k+N+4.
- Throughput: one window per cycle inside a valid row span. All outputs are registered.

## Configuration
- `NMS_FEED_SKIP_ZERO_EN`
  - Defined: `out_valid` is additionally gated off when `ref_score == 0`, so non-corner centres never reach the NMS datapath.
  - Undefined: every interior window is emitted regardless of score.
- Timing and all other behaviour are identical in both builds.

## Test plan
- Ramp image, RAM[a] = a mod 256, defaults, `start` at edge 0. Window at `ref_addr`=364 must have `ref_score`=182 and `adj_score`={0,1,2,181,183,106,107,108}, and be valid in cycle 367.
- Full frame, defaults, macro undefined: exactly 21122 `out_valid` cycles; none with column of `ref_addr` < 2; `done` in cycle 21723 only.
- All-zero image, macro defined: zero `out_valid` cycles; `done` still at cycle 21723.
- `start` pulsed again at cycles 50 and 21723: both ignored, single `done`, address sequence unbroken.
- `rst` asserted at cycle 1000 mid-READ, then `start` at 1010: outputs at reset values by cycle 1001; second scan reproduces the ramp-test result at `ref_addr`=364 in cycle 1377.
- IMG_W=4, IMG_H=3, RAM[a]=a+1: exactly 2 windows.
  - `ref_addr`=10: `ref_score`=6, adj={1,2,3,5,7,9,10,11}.
  - `ref_addr`=11: `ref_score`=7, adj={2,3,4,6,8,10,11,12}.
